// File: rtl/digit_glyph_reader_pkg.sv
// Shared definitions for the digit glyph reader: window geometry, the FSM
// state encoding and the digit template used to judge every pixel sample.
package digit_glyph_pkg;

    localparam int         GLYPH_W    = 5;
    localparam int         GLYPH_H    = 8;
    localparam int         GLYPH_PIX  = 40;
    localparam int         NUM_DIGITS = 10;
    localparam logic [3:0] DIGIT_NONE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Template pixel of digit n at window cell (c, r). Mirrors the digit
    // renderer's segment geometry, including its irregular strokes.
    function automatic logic glyph_px(input logic [3:0] n,
                                      input logic [2:0] c,
                                      input logic [2:0] r);
        logic top_bar;
        logic mid_bar;
        logic bot_bar;
        logic left_col;
        logic right_col;
        logic on;
        top_bar   = (r == 3'd0) || (r == 3'd1);
        mid_bar   = (r == 3'd3) || (r == 3'd4);
        bot_bar   = (r == 3'd6) || (r == 3'd7);
        left_col  = (c == 3'd0) || (c == 3'd1);
        right_col = (c == 3'd3) || (c == 3'd4);
        case (n)
            4'd0: on = top_bar || bot_bar || left_col || right_col;
            4'd1: on = right_col;
            4'd2: on = top_bar || mid_bar || bot_bar
                       || (right_col && r == 3'd2) || (left_col && r == 3'd5);
            // the middle bar of 3 starts one column in
            4'd3: on = top_bar || bot_bar || (mid_bar && c != 3'd0) || right_col;
            4'd4: on = mid_bar || (left_col && r <= 3'd4) || right_col;
            4'd5: on = top_bar || mid_bar || bot_bar
                       || (left_col && r == 3'd2) || (right_col && r == 3'd5);
            4'd6: on = top_bar || mid_bar || bot_bar
                       || (left_col && (r == 3'd2 || r == 3'd5))
                       || (right_col && r == 3'd5);
            4'd7: on = top_bar || right_col;
            4'd8: on = top_bar || mid_bar || bot_bar || left_col || right_col;
            4'd9: on = top_bar || mid_bar || bot_bar
                       || (left_col && r <= 3'd4) || right_col;
            default: on = 1'b0;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/digit_glyph_reader_if.sv
// Pixel stream in, digit result out.
// Stream semantics: pix_x/pix_y/pix_on are consumed on every clk edge where
// pix_valid is high; there is no ready, the reader always accepts. The result
// side is a one-cycle digit_valid strobe with digit/digit_ok held afterwards.
interface digit_glyph_reader_if;
    logic       frame_start;
    logic       pix_valid;
    logic [6:0] pix_x;
    logic [5:0] pix_y;
    logic       pix_on;
    logic       busy;
    logic       digit_valid;
    logic       digit_ok;
    logic [3:0] digit;

    modport master (
        output frame_start, pix_valid, pix_x, pix_y, pix_on,
        input  busy, digit_valid, digit_ok, digit
    );

    modport slave (
        input  frame_start, pix_valid, pix_x, pix_y, pix_on,
        output busy, digit_valid, digit_ok, digit
    );
endinterface

// File: rtl/digit_candidate_tracker.sv
// Tracks which digits still agree with the samples seen in the current
// window and encodes the verdict. Optional feature macro:
// DIGIT_READER_TOLERANCE_EN swaps the exact-match mask for per-digit
// saturating mismatch counters judged against MAX_ERR.
module digit_candidate_tracker
    import digit_glyph_pkg::*;
#(
    parameter int MAX_ERR = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,    // sample opens a fresh window
    input  logic       step,     // sample continues the current window
    input  logic       clear,    // window ended without a new sample
    input  logic       pix_on,
    input  logic [2:0] cell_c,
    input  logic [2:0] cell_r,
    output logic       result_ok,
    output logic [3:0] result_digit
);

    logic [NUM_DIGITS-1:0] mism;

    // Per-digit disagreement between the sample and the template
    always_comb begin
        mism = '0;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            mism[n] = (pix_on != glyph_px(4'(n), cell_c, cell_r));
        end
    end

`ifdef DIGIT_READER_TOLERANCE_EN

    localparam logic [5:0] ERR_LIMIT = 6'(MAX_ERR);

    logic [5:0] err [NUM_DIGITS];
    logic [5:0] best;
    logic [3:0] best_idx;
    logic       tie;

    // Saturating mismatch counters, one per digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_DIGITS; n++) err[n] <= '0;
        end else begin
            for (int n = 0; n < NUM_DIGITS; n++) begin
                if (start) begin
                    err[n] <= {5'd0, mism[n]};
                end else if (step) begin
                    if (err[n] != 6'h3F) err[n] <= err[n] + {5'd0, mism[n]};
                end else if (clear) begin
                    err[n] <= '0;
                end
            end
        end
    end

    // Unique minimum within the limit wins; ties are rejected
    always_comb begin
        best     = 6'h3F;
        best_idx = DIGIT_NONE;
        tie      = 1'b0;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (err[n] < best) begin
                best     = err[n];
                best_idx = 4'(n);
                tie      = 1'b0;
            end else if (err[n] == best) begin
                tie = 1'b1;
            end
        end
        result_ok    = !tie && (best <= ERR_LIMIT);
        result_digit = result_ok ? best_idx : DIGIT_NONE;
    end

`else

    logic [NUM_DIGITS-1:0] mask;
    logic [3:0]            hits;
    logic [3:0]            hit_idx;

    // Candidate mask: a digit survives only while every sample matched it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '1;
        end else if (start) begin
            mask <= ~mism;
        end else if (step) begin
            mask <= mask & ~mism;
        end else if (clear) begin
            mask <= '1;
        end
    end

    // Exactly one surviving candidate is a recognised digit
    always_comb begin
        hits    = '0;
        hit_idx = DIGIT_NONE;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (mask[n]) begin
                hits    = hits + 4'd1;
                hit_idx = 4'(n);
            end
        end
        result_ok    = (hits == 4'd1);
        result_digit = result_ok ? hit_idx : DIGIT_NONE;
    end

`endif

endmodule

// File: rtl/digit_glyph_reader.sv
// Reads back the single digit drawn in a 5x8 cell of the 96x64 raster.
// Window selection and the IDLE/COLLECT/DONE sequencing live here; the
// per-digit bookkeeping is in digit_candidate_tracker.
// Optional feature macro: DIGIT_READER_TOLERANCE_EN (mismatch tolerance).
module digit_glyph_reader
    import digit_glyph_pkg::*;
#(
    parameter int X       = 0,
    parameter int Y       = 0,
    parameter int MAX_ERR = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    digit_glyph_reader_if.slave    bus,
    output state_t                 fsm_state
);

    // The glyph itself sits 3 pixels into its cell in both directions
    localparam int X_LO = X + 3;
    localparam int Y_LO = Y + 3;

    state_t     state;
    logic [5:0] count;
    logic       in_win;
    logic       take;
    logic [2:0] cell_c;
    logic [2:0] cell_r;
    logic       trk_start;
    logic       trk_step;
    logic       trk_clear;
    logic       res_ok;
    logic [3:0] res_digit;

    // Widened compares so a cell at the raster edge cannot wrap
    assign in_win = ({1'b0, bus.pix_x} >= 8'(X_LO))
                 && ({1'b0, bus.pix_x} <  8'(X_LO + GLYPH_W))
                 && ({1'b0, bus.pix_y} >= 7'(Y_LO))
                 && ({1'b0, bus.pix_y} <  7'(Y_LO + GLYPH_H));
    assign take   = bus.pix_valid && in_win;
    assign cell_c = 3'(bus.pix_x - 7'(X_LO));
    assign cell_r = 3'(bus.pix_y - 6'(Y_LO));

    // A sample outside COLLECT, or one riding on frame_start, opens a window
    assign trk_start = take && ((state != S_COLLECT) || bus.frame_start);
    assign trk_step  = take && (state == S_COLLECT) && !bus.frame_start;
    assign trk_clear = !take && ((state == S_DONE)
                              || ((state == S_COLLECT) && bus.frame_start));

    digit_candidate_tracker #(
        .MAX_ERR (MAX_ERR)
    ) u_tracker (
        .clk          (clk),
        .rst          (reset),
        .start        (trk_start),
        .step         (trk_step),
        .clear        (trk_clear),
        .pix_on       (bus.pix_on),
        .cell_c       (cell_c),
        .cell_r       (cell_r),
        .result_ok    (res_ok),
        .result_digit (res_digit)
    );

    // Window sequencing with registered status and result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            count           <= '0;
            bus.busy        <= 1'b0;
            bus.digit_valid <= 1'b0;
            bus.digit_ok    <= 1'b0;
            bus.digit       <= DIGIT_NONE;
        end else begin
            bus.digit_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        state    <= S_COLLECT;
                        count    <= 6'd1;
                        bus.busy <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (bus.frame_start) begin
                        // abandon the window; a concurrent sample restarts it
                        if (take) begin
                            count <= 6'd1;
                        end else begin
                            state    <= S_IDLE;
                            count    <= '0;
                            bus.busy <= 1'b0;
                        end
                    end else if (take) begin
                        count <= count + 6'd1;
                        if (count == 6'(GLYPH_PIX - 1)) begin
                            state    <= S_DONE;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    bus.digit_valid <= 1'b1;
                    bus.digit_ok    <= res_ok;
                    bus.digit       <= res_digit;
                    // behave as IDLE so back-to-back frames lose no sample
                    if (take) begin
                        state    <= S_COLLECT;
                        count    <= 6'd1;
                        bus.busy <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        count <= '0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    count    <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_digit_glyph_reader.sv
// Directed bench for digit_glyph_reader at X = Y = 0 (glyph at cols 3..7,
// rows 3..10). Expected glyphs come from a hand-drawn font table below.
module tb_digit_glyph_reader;
    import digit_glyph_pkg::*;

    logic   clk;
    logic   reset;
    state_t fsm_state;
    int     n_checks;
    int     n_fail;

    logic [3:0] obs_digit [$];
    logic       obs_ok    [$];

    digit_glyph_reader_if bus ();

    digit_glyph_reader #(
        .X       (0),
        .Y       (0),
        .MAX_ERR (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Hand-drawn font: one 5-bit row per line, leftmost char is c=0.
    // Entry 10 is a blank cell.
    logic [4:0] font [0:10][0:7] = '{
        '{5'b11111, 5'b11111, 5'b11011, 5'b11011, 5'b11011, 5'b11011, 5'b11111, 5'b11111},
        '{5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00011},
        '{5'b11111, 5'b11111, 5'b00011, 5'b11111, 5'b11111, 5'b11000, 5'b11111, 5'b11111},
        '{5'b11111, 5'b11111, 5'b00011, 5'b01111, 5'b01111, 5'b00011, 5'b11111, 5'b11111},
        '{5'b11011, 5'b11011, 5'b11011, 5'b11111, 5'b11111, 5'b00011, 5'b00011, 5'b00011},
        '{5'b11111, 5'b11111, 5'b11000, 5'b11111, 5'b11111, 5'b00011, 5'b11111, 5'b11111},
        '{5'b11111, 5'b11111, 5'b11000, 5'b11111, 5'b11111, 5'b11011, 5'b11111, 5'b11111},
        '{5'b11111, 5'b11111, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00011},
        '{5'b11111, 5'b11111, 5'b11011, 5'b11111, 5'b11111, 5'b11011, 5'b11111, 5'b11111},
        '{5'b11111, 5'b11111, 5'b11011, 5'b11111, 5'b11111, 5'b00011, 5'b11111, 5'b11111},
        '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000}
    };

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result monitor: every digit_valid cycle is logged
    always @(negedge clk) begin
        if (bus.digit_valid === 1'b1) begin
            obs_digit.push_back(bus.digit);
            obs_ok.push_back(bus.digit_ok);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic gpx(input int n, input int c, input int r);
        logic [4:0] row;
        row = font[n][r];
        return row[4-c];
    endfunction

    task automatic send(input int x, input int y, input logic on, input logic fs);
        @(negedge clk);
        bus.frame_start = fs;
        bus.pix_valid   = 1'b1;
        bus.pix_x       = 7'(x);
        bus.pix_y       = 6'(y);
        bus.pix_on      = on;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.frame_start = 1'b0;
            bus.pix_valid   = 1'b0;
            bus.pix_on      = 1'b0;
        end
    endtask

    task automatic pulse_frame_start();
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.pix_valid   = 1'b0;
        bus.pix_on      = 1'b0;
    endtask

    // Window samples in raster order; optionally one pixel inverted
    task automatic stream_glyph(input int n, input int nsamp, input int flip_c,
                                input int flip_r, input logic fs_first);
        int idx;
        idx = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (idx < nsamp)
                    send(c + 3, r + 3, gpx(n, c, r) ^ ((c == flip_c) && (r == flip_r)),
                         fs_first && (idx == 0));
                idx++;
            end
        end
    endtask

    task automatic clear_obs();
        obs_digit.delete();
        obs_ok.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.pix_x       = '0;
        bus.pix_y       = '0;
        bus.pix_on      = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++;
        if (bus.digit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_digit_valid: got %b want 0", bus.digit_valid); end
        n_checks++;
        if (bus.digit_ok !== 1'b0) begin n_fail++; $display("FAIL reset_digit_ok: got %b want 0", bus.digit_ok); end
        n_checks++;
        if (bus.digit !== 4'hF) begin n_fail++; $display("FAIL reset_digit: got %h want f", bus.digit); end
        n_checks++;
        if (fsm_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_full_raster_7();
        logic on;
        clear_obs();
        pulse_frame_start();
        for (int y = 0; y < 64; y++) begin
            for (int x = 0; x < 96; x++) begin
                on = (x >= 3 && x < 8 && y >= 3 && y < 11) ? gpx(7, x - 3, y - 3) : 1'b0;
                send(x, y, on, 1'b0);
            end
        end
        idle(4);
        n_checks++;
        if (obs_digit.size() != 1) begin n_fail++; $display("FAIL raster7_pulses: got %0d want 1", obs_digit.size()); end
        n_checks++;
        if (bus.digit !== 4'd7) begin n_fail++; $display("FAIL raster7_digit: got %h want 7", bus.digit); end
        n_checks++;
        if (bus.digit_ok !== 1'b1) begin n_fail++; $display("FAIL raster7_ok: got %b want 1", bus.digit_ok); end
    endtask

    task automatic test_latency();
        clear_obs();
        stream_glyph(4, 40, -1, -1, 1'b0);
        // edge k has taken sample 40: DONE, no pulse yet
        @(negedge clk);
        bus.pix_valid = 1'b0;
        n_checks++;
        if (bus.digit_valid !== 1'b0 || fsm_state !== S_DONE) begin
            n_fail++; $display("FAIL latency_edge_k: dv %b state %0d want dv 0 state 2", bus.digit_valid, fsm_state);
        end
        @(negedge clk);
        n_checks++;
        if (bus.digit_valid !== 1'b1 || bus.digit !== 4'd4 || bus.digit_ok !== 1'b1) begin
            n_fail++; $display("FAIL latency_edge_k1: dv %b digit %h ok %b want 1 4 1", bus.digit_valid, bus.digit, bus.digit_ok);
        end
        @(negedge clk);
        n_checks++;
        if (bus.digit_valid !== 1'b0) begin n_fail++; $display("FAIL latency_pulse_width: dv %b want 0", bus.digit_valid); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        clear_obs();
        stream_glyph(3, 40, -1, -1, 1'b0);
        stream_glyph(8, 40, -1, -1, 1'b0);
        idle(4);
        n_checks++;
        if (obs_digit.size() != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", obs_digit.size()); end
        n_checks++;
        if (obs_digit.size() < 1 || obs_digit[0] !== 4'd3 || obs_ok[0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: got %h want 3", (obs_digit.size() > 0) ? obs_digit[0] : 4'hx);
        end
        n_checks++;
        if (obs_digit.size() < 2 || obs_digit[1] !== 4'd8 || obs_ok[1] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second: got %h want 8", (obs_digit.size() > 1) ? obs_digit[1] : 4'hx);
        end
    endtask

    task automatic test_all_off();
        clear_obs();
        stream_glyph(10, 40, -1, -1, 1'b0);
        idle(4);
        n_checks++;
        if (obs_digit.size() != 1) begin n_fail++; $display("FAIL blank_pulses: got %0d want 1", obs_digit.size()); end
        n_checks++;
        if (bus.digit_ok !== 1'b0 || bus.digit !== 4'hF) begin
            n_fail++; $display("FAIL blank_result: digit %h ok %b want f 0", bus.digit, bus.digit_ok);
        end
    endtask

    task automatic test_flipped_8();
        logic [3:0] exp_digit;
        logic       exp_ok;
`ifdef DIGIT_READER_TOLERANCE_EN
        exp_digit = 4'd8;
        exp_ok    = 1'b1;
`else
        exp_digit = 4'hF;
        exp_ok    = 1'b0;
`endif
        clear_obs();
        stream_glyph(8, 40, 2, 0, 1'b0);
        idle(4);
        n_checks++;
        if (obs_digit.size() != 1) begin n_fail++; $display("FAIL flip8_pulses: got %0d want 1", obs_digit.size()); end
        n_checks++;
        if (bus.digit !== exp_digit || bus.digit_ok !== exp_ok) begin
            n_fail++; $display("FAIL flip8_result: digit %h ok %b want %h %b", bus.digit, bus.digit_ok, exp_digit, exp_ok);
        end
    endtask

    task automatic test_abort();
        clear_obs();
        stream_glyph(5, 40, -1, -1, 1'b0);
        idle(4);
        n_checks++;
        if (bus.digit !== 4'd5 || bus.digit_ok !== 1'b1) begin
            n_fail++; $display("FAIL abort_pre: digit %h ok %b want 5 1", bus.digit, bus.digit_ok);
        end
        clear_obs();
        pulse_frame_start();
        stream_glyph(2, 20, -1, -1, 1'b0);
        idle(1);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_mid: got %b want 1", bus.busy); end
        pulse_frame_start();
        idle(3);
        n_checks++;
        if (bus.busy !== 1'b0 || obs_digit.size() != 0 || bus.digit !== 4'd5) begin
            n_fail++; $display("FAIL abort_hold: busy %b pulses %0d digit %h want 0 0 5", bus.busy, obs_digit.size(), bus.digit);
        end
        stream_glyph(2, 40, -1, -1, 1'b0);
        idle(4);
        n_checks++;
        if (obs_digit.size() != 1 || bus.digit !== 4'd2 || bus.digit_ok !== 1'b1) begin
            n_fail++; $display("FAIL abort_then_2: pulses %0d digit %h want 1 2", obs_digit.size(), bus.digit);
        end
        // frame_start together with the first sample of the next window
        clear_obs();
        stream_glyph(9, 10, -1, -1, 1'b0);
        stream_glyph(0, 40, -1, -1, 1'b1);
        idle(4);
        n_checks++;
        if (obs_digit.size() != 1 || bus.digit !== 4'd0 || bus.digit_ok !== 1'b1) begin
            n_fail++; $display("FAIL abort_restart_0: pulses %0d digit %h want 1 0", obs_digit.size(), bus.digit);
        end
    endtask

    task automatic test_noise_and_reset();
        logic on;
        clear_obs();
        // lit border one pixel around the cell must be ignored
        for (int y = 2; y < 12; y++) begin
            for (int x = 2; x < 9; x++) begin
                on = (x >= 3 && x < 8 && y >= 3 && y < 11) ? gpx(1, x - 3, y - 3) : 1'b1;
                send(x, y, on, 1'b0);
            end
        end
        idle(4);
        n_checks++;
        if (obs_digit.size() != 1 || bus.digit !== 4'd1 || bus.digit_ok !== 1'b1) begin
            n_fail++; $display("FAIL noise_1: pulses %0d digit %h ok %b want 1 1 1", obs_digit.size(), bus.digit, bus.digit_ok);
        end
        clear_obs();
        stream_glyph(1, 30, -1, -1, 1'b0);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_reset_busy_before: got %b want 1", bus.busy); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.digit !== 4'hF || bus.digit_ok !== 1'b0 || fsm_state !== S_IDLE) begin
            n_fail++; $display("FAIL mid_reset_clear: busy %b digit %h ok %b state %0d want 0 f 0 0",
                               bus.busy, bus.digit, bus.digit_ok, fsm_state);
        end
        idle(3);
        reset = 1'b0;
        idle(6);
        n_checks++;
        if (obs_digit.size() != 0 || bus.digit !== 4'hF) begin
            n_fail++; $display("FAIL mid_reset_no_pulse: pulses %0d digit %h want 0 f", obs_digit.size(), bus.digit);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_full_raster_7();
        test_latency();
        test_back_to_back();
        test_all_off();
        test_flipped_8();
        test_abort();
        test_noise_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_glyph_reader.md
# digit_glyph_reader

Recognises a single decimal digit drawn on the 96x64 OLED pixel raster. It watches a stream of (x, y, on) pixel samples from the frame generator and compares the 5x8 glyph window at offset (X, Y) against the team's digit-renderer geometry for 0–9. Once per frame it reports which digit is displayed, or that none matches. It sits beside the display pipeline as a self-check and score read-back path: it is the decoder for the digit renderer's encoder.

## Interface
Parameters:
- X — 0 — glyph cell x offset; the glyph occupies columns X+3..X+7.
- Y — 0 — glyph cell y offset; the glyph occupies rows Y+3..Y+10.
- MAX_ERR — 2 — mismatch tolerance, used only when DIGIT_READER_TOLERANCE_EN is defined.

Ports:
- clk — in — 1 — system clock.
- reset — in — 1 — asynchronous, active-high reset.
- frame_start — in — 1 — one-cycle pulse marking the start of a new frame.
- pix_valid — in — 1 — pix_x, pix_y and pix_on are valid this cycle.
- pix_x — in — 7 — pixel column, 0..95.
- pix_y — in — 6 — pixel row, 0..63.
- pix_on — in — 1 — pixel is lit.
- busy — out — 1 — a window collection is in progress.
- digit_valid — out — 1 — one-cycle pulse: the result registers were updated.
- digit_ok — out — 1 — a unique digit was recognised; held until the next result.
- digit — out — 4 — recognised digit 0..9; 4'hF when not recognised; held until the next result.

## Operation
- Window cell coordinates: c = pix_x − X − 3 (0..4), r = pix_y − Y − 3 (0..7). Samples outside the window are ignored.
- Template bit glyph(n, c, r) is built from these segments:
  - top bar: r0–1; middle bar: r3–4; bottom bar: r6–7.
  - left strokes: c0–1; right strokes: c3–4.
- Template quirks, which must be matched exactly:
  - The middle bar of 3 spans c1..c4.
  - 4 and 9 have a left stroke on r0–4 only.
  - 1 and 7 use the full-height right stroke (r0–7).
  - 2 has the right stroke on r2 and the left stroke on r5.
  - 5 has the left stroke on r2 and the right stroke on r5.
  - 6 is 5 plus the left stroke on r5.
  - 0 and 8 have both full-height strokes; 0 has no middle bar.
- State machine IDLE → COLLECT → DONE → IDLE:
  - IDLE: the first in-window sample moves to COLLECT. That sample is evaluated, sample count becomes 1, and the candidate mask starts at 10'h3FF.
  - COLLECT: each in-window sample increments the 6-bit sample count and clears candidate n when pix_on ≠ glyph(n, c, r). Reaching count 40 moves to DONE.
  - DONE: result is digit_ok = (exactly one candidate bit set), digit = index of that bit or 4'hF. digit_valid pulses. Return to IDLE with the mask reset to all ones.
- Coordinate order is not checked. Duplicate in-window samples are counted.
- frame_start aborts COLLECT: no result is produced, digit and digit_ok are held, and the block returns to IDLE. If pix_valid is high in the same cycle, that sample is treated as the first sample of a new collection.
- busy = (state == COLLECT).

## Timing
- Reset values: busy 0, digit_valid 0, digit_ok 0, digit 4'hF, state IDLE, count 0, mask 10'h3FF.
- A sample is registered on the clk edge where pix_valid is high.
- The 40th sample is accepted at edge k. digit, digit_ok and digit_valid update at edge k+1. digit_valid is high for exactly one cycle.
- A new sample may arrive every cycle. A sample arriving during DONE is evaluated as in IDLE, so back-to-back frames lose no samples.
- Reset asserted mid-collection clears all state immediately. No digit_valid is produced.

## Configuration
- DIGIT_READER_TOLERANCE_EN:
  - Defined: per-candidate 6-bit mismatch counters (saturating at 63) replace the candidate mask. At DONE, the result is the digit with the minimum count, provided that count ≤ MAX_ERR and the minimum is unique. Otherwise digit_ok = 0 and digit = 4'hF.
  - Not defined: exact match only, equivalent to MAX_ERR = 0 with tie rejection; the counters are not built.

## Structure
- Package digit_glyph_pkg contains:
  - constants GLYPH_W = 5, GLYPH_H = 8, GLYPH_PIX = 40, DIGIT_NONE = 4'hF;
  - the state enum;
  - a pure function glyph_px(n, c, r) encoding the template geometry above.
- One sub-module, digit_candidate_tracker: holds the candidate mask (or the mismatch counters under the macro) and produces the result encoding. The FSM and window logic stay in the top level.

## Test plan
- Stream a full raster with the window drawn as glyph 7 (X=Y=0) → digit_valid pulses once; digit = 7, digit_ok = 1.
- Draw glyph 3, then glyph 8 in the next frame → two pulses, with digit = 3 then digit = 8.
- All pixels off → digit_ok = 0, digit = 4'hF.
- Glyph 8 with pixel (c=2, r=0) flipped off → without the macro: digit_ok = 0. With the macro and MAX_ERR = 2: digit = 8, digit_ok = 1.
- After glyph 5 is recognised, start a frame, assert frame_start after 20 window samples, then stream glyph 2 → no pulse for the aborted frame; digit holds 5, then becomes 2.
- Lit pixels outside the window around glyph 1, then reset asserted at sample 30 of the next frame → first result digit = 1; after reset, digit = 4'hF and no pulse.
